// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// Load hits return data in the same cycle; misses and stores go through the backing memory.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     core_addr,
  input  logic [0:3][7:0] core_wdata,
  input  logic            core_re,
  input  logic            core_we,
  output logic [0:3][7:0] core_rdata,
  output logic            core_stall,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_wdata,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  input  logic [0:3][7:0] mem_rdata
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [31:0]           wordAddr;
  logic                  hit;
  logic                  lineWe;
  logic [31:0]           lineWdata;
  logic                  unusedAddrBits;

  assign index          = core_addr[INDEX_BITS+1:2];
  assign tag            = core_addr[31:INDEX_BITS+2];
  assign wordAddr       = {core_addr[31:2], 2'b00};
  assign hit            = valid_q[index] && (tag_q[index] == tag);
  assign unusedAddrBits = ^core_addr[1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // The core holds its request while stalled, so the memory-side outputs can
  // be derived from it combinationally and still stay stable until the ack.
  always_ff @(posedge clk) begin
    if (lineWe) begin
      data_q[index] <= lineWdata;
      tag_q[index]  <= tag;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    lineWe     = 1'b0;
    lineWdata  = '0;
    core_stall = 1'b0;
    core_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        if (core_we) begin
          core_stall = 1'b1;
          state_d    = WRITE;
        end else if (core_re) begin
          if (hit) begin
            core_rdata = data_q[index];
          end else begin
            core_stall = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = wordAddr;
        if (mem_ack) begin
          lineWe         = 1'b1;
          lineWdata      = mem_rdata;
          valid_d[index] = 1'b1;
          core_rdata     = mem_rdata;
          state_d        = IDLE;
        end else begin
          core_stall = 1'b1;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wordAddr;
        mem_wdata = core_wdata;
        if (mem_ack) begin
          // Write-through without allocation: only a resident line is refreshed.
          lineWe    = hit;
          lineWdata = core_wdata;
          state_d   = IDLE;
        end else begin
          core_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_b) begin
      core_stall = 1'b0;
      core_rdata = '0;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios then random accesses,
// compared against a line-occupancy model of the cache and a word-addressed backing memory.
module tb_data_cache;

  localparam int LINES = 8;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic [31:0]     core_addr = '0;
  logic [0:3][7:0] core_wdata = '0;
  logic            core_re = 1'b0;
  logic            core_we = 1'b0;
  logic [0:3][7:0] core_rdata;
  logic            core_stall;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_wdata;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack = 1'b0;
  logic [0:3][7:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  // Model: which word address each line holds (-1 = empty) and its data.
  int          lineWord [LINES];
  logic [31:0] lineData [LINES];
  logic [31:0] backing  [int unsigned];

  data_cache #(.INDEX_BITS(3)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_re    (core_re),
    .core_we    (core_we),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    core_re    = re;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
  endtask

  function automatic logic [31:0] backingRead(input int unsigned word);
    if (!backing.exists(word)) backing[word] = $urandom;
    return backing[word];
  endfunction

  task automatic invalidateModel();
    for (int i = 0; i < LINES; i++) lineWord[i] = -1;
  endtask

  // One complete core access, checking every cycle until the cache is idle again.
  task automatic doAccess(input logic re, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ackDelay);
    int          word;
    int          idx;
    bit          hit;
    logic [31:0] expAddr;
    logic [31:0] fillData;
    word    = int'(addr >> 2);
    idx     = word % LINES;
    hit     = (lineWord[idx] == word);
    expAddr = addr & 32'hFFFF_FFFC;

    @(negedge clk);
    applyStimulus(re, we, addr, wdata);
    #1;
    if (!we && hit) begin
      checkOutput("hit stall", 32'(core_stall), 32'd0);
      checkOutput("hit rdata", core_rdata, lineData[idx]);
      checkOutput("hit mem_req", 32'(mem_req), 32'd0);
    end else begin
      checkOutput("start stall", 32'(core_stall), 32'd1);
      checkOutput("start mem_req", 32'(mem_req), 32'd0);
      checkOutput("start rdata", core_rdata, 32'd0);
      fillData = we ? wdata : backingRead(word);
      for (int k = 0; k <= ackDelay; k++) begin
        @(negedge clk);
        mem_ack   = (k == ackDelay);
        mem_rdata = (k == ackDelay) ? fillData : $urandom;
        #1;
        checkOutput("mem_req", 32'(mem_req), 32'd1);
        checkOutput("mem_we", 32'(mem_we), 32'(we));
        checkOutput("mem_addr", mem_addr, expAddr);
        if (we) checkOutput("mem_wdata", mem_wdata, wdata);
        checkOutput("busy stall", 32'(core_stall), 32'(k != ackDelay));
        checkOutput("busy rdata", core_rdata, (!we && k == ackDelay) ? fillData : 32'd0);
      end
      if (we) begin
        backing[word] = wdata;
        if (hit) lineData[idx] = wdata;
      end else begin
        lineWord[idx] = word;
        lineData[idx] = fillData;
      end
    end

    @(negedge clk);
    applyStimulus(1'b0, 1'b0, $urandom, $urandom);
    mem_ack = 1'b0;
    #1;
    checkOutput("idle stall", 32'(core_stall), 32'd0);
    checkOutput("idle mem_req", 32'(mem_req), 32'd0);
    checkOutput("idle rdata", core_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    int          op;
    invalidateModel();

    // Reset held with a pending load: everything quiet.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("reset stall", 32'(core_stall), 32'd0);
    checkOutput("reset rdata", core_rdata, 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    rst_b = 1'b1;

    // Fill, hit, write-through hit, write-through miss.
    backing[32'h10 >> 2] = 32'hDEADBEEF;
    doAccess(1'b1, 1'b0, 32'h10, 32'h0, 0);
    doAccess(1'b1, 1'b0, 32'h10, 32'h0, 0);
    doAccess(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 0);
    doAccess(1'b1, 1'b0, 32'h10, 32'h0, 0);
    doAccess(1'b0, 1'b1, 32'h30, 32'h11111111, 1);
    doAccess(1'b1, 1'b0, 32'h30, 32'h0, 0);

    // Conflicting tags on index 1.
    doAccess(1'b1, 1'b0, 32'h04, 32'h0, 0);
    doAccess(1'b1, 1'b0, 32'h24, 32'h0, 2);
    doAccess(1'b1, 1'b0, 32'h04, 32'h0, 0);

    // Slow memory, then a stray ack while idle.
    doAccess(1'b1, 1'b0, 32'h48, 32'h0, 5);
    doAccess(1'b1, 1'b1, 32'h48, 32'h5A5A_A5A5, 5);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    checkOutput("spurious mem_req", 32'(mem_req), 32'd0);
    checkOutput("spurious stall", 32'(core_stall), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    doAccess(1'b1, 1'b0, 32'h48, 32'h0, 0);

    // Reset in the middle of a fill.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0);
    #1;
    checkOutput("pre-reset stall", 32'(core_stall), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("fill mem_req", 32'(mem_req), 32'd1);
    rst_b = 1'b0;
    #1;
    checkOutput("abort mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort mem_addr", mem_addr, 32'd0);
    checkOutput("abort stall", 32'(core_stall), 32'd0);
    checkOutput("abort rdata", core_rdata, 32'd0);
    invalidateModel();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    doAccess(1'b1, 1'b0, 32'h48, 32'h0, 0);

    // Random traffic over a small address pool to provoke hits and conflicts.
    for (int n = 0; n < 120; n++) begin
      addr = ($urandom_range(0, 1) << 31) | ($urandom_range(0, 3) << 5)
           | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      doAccess(op != 2, op >= 2, addr, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
